pipe_hazard_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline. It drives hold/flush enables for PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB, and forwarding selects for the EX-stage ALU operands. It also sequences the EX/MEM

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select
// encodings and FSM state codes.
package pipe_hazard_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [1:0] fwd_sel_t;

  // Forwarding select encodings for the EX-stage operand muxes
  localparam fwd_sel_t FWD_REG   = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

  // FSM state codes
  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_MEMWAIT = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX-stage ALU operand. The younger producer
// (EX/MEM) wins over MEM/WB; register $0 is never forwarded.
module pipe_hazard_ctrl_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_addr,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_addr,
  output logic [1:0] sel
);

  // Priority select: EX/MEM result, then MEM/WB result, else register file
  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_addr != 5'd0) && (mem_addr == src))
      sel = FWD_EXMEM;
    else if (wb_reg_write && (wb_addr != 5'd0) && (wb_addr == src))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: memory-wait freeze FSM,
// branch flush, load-use interlock, operand forwarding and stall statistics.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | pipeline flowing; branch/load-use decode active
// ST_MEMWAIT | data memory access outstanding; whole pipe frozen
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       EX_rs,
  input  logic [4:0]       EX_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteAddress,
  input  logic             EX_Branch,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic [4:0]       MEM_WriteAddress,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteAddress,
  input  logic             mem_ready,
  output logic             PC_stall,
  output logic             IFID_stall,
  output logic             IFID_flush,
  output logic             IDEX_stall,
  output logic             IDEX_flush,
  output logic             EXMEM_stall,
  output logic             MEMWB_bubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT);

  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic          mem_access;
  logic          in_wait;
  logic          freeze;
  logic          branch_flush;
  logic          load_use;

  // Mealy stall/flush decode; memory freeze overrides branch and load-use.
  // Reset gates every request so outputs drop the instant reset rises.
  always_comb begin
    mem_access   = MEM_MemRead | MEM_MemWrite;
    in_wait      = (state == ST_MEMWAIT);
    freeze       = !reset && !mem_ready && (in_wait || mem_access);
    branch_flush = !reset && !freeze && EX_Branch;
    load_use     = !reset && !freeze && !EX_Branch && EX_MemRead &&
                   (EX_WriteAddress != 5'd0) &&
                   ((EX_WriteAddress == ID_rs) || (EX_WriteAddress == ID_rt));

    PC_stall     = freeze | load_use;
    IFID_stall   = freeze | load_use;
    IFID_flush   = branch_flush;
    IDEX_stall   = freeze;
    IDEX_flush   = branch_flush | load_use;
    EXMEM_stall  = freeze;
    // On a timeout exit the bubble is still asserted, dropping the access.
    MEMWB_bubble = freeze;
  end

  // Memory-wait FSM with bounded wait and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (in_wait) begin
      if (mem_ready) begin
        state    <= ST_RUN;
        wait_cnt <= '0;
      end else if (wait_cnt == WAIT_LAST) begin
        state       <= ST_RUN;
        wait_cnt    <= '0;
        mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end else begin
      state <= ST_RUN;
      if (mem_access && !mem_ready) begin
        state    <= ST_MEMWAIT;
        wait_cnt <= WW'(1);
      end
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (PC_stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

  pipe_hazard_ctrl_fwd_unit u_fwd_a (
    .src           (EX_rs),
    .mem_reg_write (MEM_RegWrite),
    .mem_addr      (MEM_WriteAddress),
    .wb_reg_write  (WB_RegWrite),
    .wb_addr       (WB_WriteAddress),
    .sel           (ForwardA)
  );

  pipe_hazard_ctrl_fwd_unit u_fwd_b (
    .src           (EX_rt),
    .mem_reg_write (MEM_RegWrite),
    .mem_addr      (MEM_WriteAddress),
    .wb_reg_write  (WB_RegWrite),
    .wb_addr       (WB_WriteAddress),
    .sel           (ForwardB)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rs = '0, EX_rt = '0;
  logic       EX_MemRead = 1'b0, EX_Branch = 1'b0;
  logic [4:0] EX_WriteAddress = '0;
  logic       MEM_RegWrite = 1'b0, MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;
  logic [4:0] MEM_WriteAddress = '0;
  logic       WB_RegWrite = 1'b0;
  logic [4:0] WB_WriteAddress = '0;
  logic       mem_ready = 1'b0;

  logic             PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush;
  logic             EXMEM_stall, MEMWB_bubble, mem_timeout;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] stall_count;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rs(EX_rs), .EX_rt(EX_rt),
    .EX_MemRead(EX_MemRead), .EX_WriteAddress(EX_WriteAddress), .EX_Branch(EX_Branch),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_WriteAddress(MEM_WriteAddress), .WB_RegWrite(WB_RegWrite),
    .WB_WriteAddress(WB_WriteAddress), .mem_ready(mem_ready),
    .PC_stall(PC_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
    .IDEX_stall(IDEX_stall), .IDEX_flush(IDEX_flush), .EXMEM_stall(EXMEM_stall),
    .MEMWB_bubble(MEMWB_bubble), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frozen cycles already spent on the pending access,
  // sticky timeout, and total stalled cycles (saturating).
  int m_held     = 0;
  bit m_timeout  = 1'b0;
  int m_stalls   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Youngest in-flight writer of src supplies the operand; $0 never forwards.
  function automatic logic [1:0] fwd_ref(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (MEM_RegWrite && MEM_WriteAddress == src) return 2'b10;
    if (WB_RegWrite && WB_WriteAddress == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    ID_rs = 0; ID_rt = 0; EX_rs = 0; EX_rt = 0;
    EX_MemRead = 0; EX_WriteAddress = 0; EX_Branch = 0;
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_MemWrite = 0; MEM_WriteAddress = 0;
    WB_RegWrite = 0; WB_WriteAddress = 0; mem_ready = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_PC_stall"},     PC_stall,     0);
    chk({tag, "_IFID_stall"},   IFID_stall,   0);
    chk({tag, "_IFID_flush"},   IFID_flush,   0);
    chk({tag, "_IDEX_stall"},   IDEX_stall,   0);
    chk({tag, "_IDEX_flush"},   IDEX_flush,   0);
    chk({tag, "_EXMEM_stall"},  EXMEM_stall,  0);
    chk({tag, "_MEMWB_bubble"}, MEMWB_bubble, 0);
    chk({tag, "_mem_timeout"},  mem_timeout,  0);
    chk({tag, "_stall_count"},  stall_count,  0);
  endtask

  // Reset pulse that ends one step after a rising edge, like tick()
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_quiet("reset");
    m_held = 0; m_timeout = 0; m_stalls = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: check all outputs against the model, then advance it
  task automatic tick();
    bit acc, frz, br, lu;
    #2;
    acc = MEM_MemRead | MEM_MemWrite;
    frz = (m_held > 0) ? !mem_ready : (acc && !mem_ready);
    br  = !frz && EX_Branch;
    lu  = !frz && !EX_Branch && EX_MemRead && (EX_WriteAddress != 0) &&
          (EX_WriteAddress == ID_rs || EX_WriteAddress == ID_rt);
    chk("PC_stall",     PC_stall,     frz | lu);
    chk("IFID_stall",   IFID_stall,   frz | lu);
    chk("IFID_flush",   IFID_flush,   br);
    chk("IDEX_stall",   IDEX_stall,   frz);
    chk("IDEX_flush",   IDEX_flush,   br | lu);
    chk("EXMEM_stall",  EXMEM_stall,  frz);
    chk("MEMWB_bubble", MEMWB_bubble, frz);
    chk("ForwardA",     ForwardA,     fwd_ref(EX_rs));
    chk("ForwardB",     ForwardB,     fwd_ref(EX_rt));
    chk("mem_timeout",  mem_timeout,  m_timeout);
    chk("stall_count",  stall_count,  m_stalls);
    @(posedge clk);
    if (frz | lu) m_stalls = (m_stalls + 1 > CNT_MAX) ? CNT_MAX : m_stalls + 1;
    if (!frz)                 m_held = 0;
    else if (m_held == MAX_WAIT) begin
      m_held = 0;
      m_timeout = 1'b1;
    end else                  m_held++;
    #1;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    tick();

    // Load-use interlock, then the bubble removes the load from EX
    EX_MemRead = 1; EX_WriteAddress = 5; ID_rs = 5;
    tick();
    EX_MemRead = 0;
    tick();
    EX_MemRead = 1; EX_WriteAddress = 7; ID_rs = 1; ID_rt = 7;
    tick();
    EX_MemRead = 1; EX_WriteAddress = 0; ID_rs = 0; ID_rt = 0;
    tick();
    clear_inputs();

    // Forwarding priority and the $0 exclusion
    MEM_RegWrite = 1; MEM_WriteAddress = 3; WB_RegWrite = 1; WB_WriteAddress = 3; EX_rs = 3;
    tick();
    chk("fwd_a_exmem", ForwardA, 2'b10);
    MEM_RegWrite = 0;
    tick();
    chk("fwd_a_memwb", ForwardA, 2'b01);
    EX_rt = 0; MEM_RegWrite = 1; MEM_WriteAddress = 0; WB_WriteAddress = 0;
    tick();
    chk("fwd_b_zero", ForwardB, 2'b00);
    clear_inputs();

    // Memory wait of three cycles released by ready
    do_reset();
    MEM_MemRead = 1; mem_ready = 0;
    repeat (3) tick();
    mem_ready = 1;
    tick();
    chk("memwait_stall_count", stall_count, 3);
    clear_inputs();
    tick();

    // Timeout: ready never arrives
    MEM_MemRead = 1; mem_ready = 0;
    repeat (MAX_WAIT + 1) tick();
    chk("timeout_set", mem_timeout, 1);
    MEM_MemRead = 0;
    repeat (3) tick();
    chk("timeout_sticky", mem_timeout, 1);

    // Branch wins over load-use; freeze wins over branch
    do_reset();
    EX_Branch = 1; EX_MemRead = 1; EX_WriteAddress = 9; ID_rt = 9;
    tick();
    clear_inputs();
    MEM_MemWrite = 1; mem_ready = 0;
    tick();
    EX_Branch = 1;
    tick();
    mem_ready = 1;
    tick();
    clear_inputs();
    tick();

    // Stall counter saturation
    do_reset();
    EX_MemRead = 1; EX_WriteAddress = 4; ID_rs = 4;
    repeat (CNT_MAX + 3) tick();
    chk("stall_count_sat", stall_count, CNT_MAX);
    clear_inputs();

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    MEM_MemRead = 1; mem_ready = 0;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    m_held = 0; m_timeout = 0; m_stalls = 0;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      ID_rs            = 5'($urandom_range(0, 3));
      ID_rt            = 5'($urandom_range(0, 3));
      EX_rs            = 5'($urandom_range(0, 3));
      EX_rt            = 5'($urandom_range(0, 3));
      EX_MemRead       = ($urandom_range(0, 1) == 0);
      EX_WriteAddress  = 5'($urandom_range(0, 3));
      EX_Branch        = ($urandom_range(0, 7) == 0);
      MEM_RegWrite     = ($urandom_range(0, 1) == 0);
      MEM_MemRead      = ($urandom_range(0, 5) == 0);
      MEM_MemWrite     = ($urandom_range(0, 7) == 0);
      MEM_WriteAddress = 5'($urandom_range(0, 3));
      WB_RegWrite      = ($urandom_range(0, 1) == 0);
      WB_WriteAddress  = 5'($urandom_range(0, 3));
      mem_ready        = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
